// File: rtl/array_ram_pkg.sv
// array_ram_pkg: shared definitions for the array_ram slice.
//   - default address/data widths (tied to the codebase addrN / intN)
//   - handshake FSM state encoding and its enum type
//   - flattened width of an `Array` port bundle (addr+we+di+do+valid+ready)
// Optional feature macro: ARRAY_CLEAR_EN (adds the CLEAR state).
package array_ram_pkg;

  localparam int unsigned ARRAY_ADDR_N = 8;  // addrN
  localparam int unsigned ARRAY_DATA_N = 8;  // intN

  localparam int unsigned STATE_IDLE  = 0;
  localparam int unsigned STATE_RESP  = 1;
  localparam int unsigned STATE_CLEAR = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'(STATE_IDLE),
    ST_RESP  = 2'(STATE_RESP),
    ST_CLEAR = 2'(STATE_CLEAR)
  } array_state_e;

  localparam int unsigned ARRAY_PORT_W =
    ARRAY_ADDR_N + 1 + ARRAY_DATA_N + ARRAY_DATA_N + 1 + 1;

endpackage

// File: rtl/array_ram_core_sp.sv
// ram_core_sp: plain synchronous single-port memory, write-first.
// Ports:
//   i_clk   clock (rising edge)
//   i_en    access enable; nothing changes when low
//   i_we    1 = write, 0 = read
//   i_addr  word address; addresses >= DEPTH are outside the array
//   i_di    write data
//   o_do    registered response (write data on writes, stored word on reads)
// Out-of-range writes are dropped but still echo i_di; out-of-range reads give 0.
module ram_core_sp #(
  parameter int unsigned ADDR_N = 8,
  parameter int unsigned DATA_N = 8,
  parameter int unsigned DEPTH  = 2 ** ADDR_N
) (
  input  logic              i_clk,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [ADDR_N-1:0] i_addr,
  input  logic [DATA_N-1:0] i_di,
  output logic [DATA_N-1:0] o_do
);

  logic [DATA_N-1:0] r_mem [DEPTH];
  logic [DATA_N-1:0] r_do;
  logic              w_in_range;

  assign w_in_range = ({1'b0, i_addr} < (ADDR_N + 1)'(DEPTH));

  always_ff @(posedge i_clk) begin
    if (i_en) begin
      if (i_we) begin
        if (w_in_range) begin
          r_mem[i_addr] <= i_di;
        end
        r_do <= i_di;
      end else begin
        r_do <= w_in_range ? r_mem[i_addr] : '0;
      end
    end
  end

  assign o_do = r_do;

endmodule

// File: rtl/array_ram.sv
// array_ram: single-port RAM behind a valid/ready request handshake, backing
// `Array`-typed ports of generated compute kernels.
// Ports:
//   i_clk    system clock (rising edge)
//   i_nrst   synchronous active-low reset
//   i_addr   request word address
//   i_we     1 = write, 0 = read
//   i_di     write data (ignored on reads)
//   i_valid  request strobe, held until o_ready is seen
//   o_do     registered response data
//   o_ready  one-cycle pulse in the cycle after acceptance
// Optional feature macro: ARRAY_CLEAR_EN -- after reset the memory is zeroed
// one word per cycle before any request is accepted.
module array_ram
  import array_ram_pkg::*;
#(
  parameter int unsigned ADDR_N = ARRAY_ADDR_N,
  parameter int unsigned DATA_N = ARRAY_DATA_N,
  parameter int unsigned DEPTH  = 2 ** ADDR_N
) (
  input  logic              i_clk,
  input  logic              i_nrst,
  input  logic [ADDR_N-1:0] i_addr,
  input  logic              i_we,
  input  logic [DATA_N-1:0] i_di,
  input  logic              i_valid,
  output logic [DATA_N-1:0] o_do,
  output logic              o_ready
);

  array_state_e      r_state;
  array_state_e      w_state_nxt;
  logic              r_do_zero;
  logic              w_accept;
  logic              w_ready;
  logic              w_core_en;
  logic              w_core_we;
  logic [ADDR_N-1:0] w_core_addr;
  logic [DATA_N-1:0] w_core_di;
  logic [DATA_N-1:0] w_core_do;

`ifdef ARRAY_CLEAR_EN
  localparam array_state_e     RESET_STATE = ST_CLEAR;
  localparam logic [ADDR_N-1:0] CLR_LAST   = ADDR_N'(DEPTH - 1);
  logic [ADDR_N-1:0] r_clr_addr;

  always_ff @(posedge i_clk) begin
    if (!i_nrst || (r_state != ST_CLEAR)) begin
      r_clr_addr <= '0;
    end else begin
      r_clr_addr <= r_clr_addr + 1'b1;
    end
  end
`else
  localparam array_state_e RESET_STATE = ST_IDLE;
`endif

  // The core's output register has no reset; the response is forced to zero
  // from reset until the first accepted request reloads the core register.
  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      r_state   <= RESET_STATE;
      r_do_zero <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_do_zero <= 1'b0;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_ready     = 1'b0;
    w_core_en   = 1'b0;
    w_core_we   = i_we;
    w_core_addr = i_addr;
    w_core_di   = i_di;
    case (r_state)
      ST_IDLE: begin
        if (i_valid) begin
          w_accept    = 1'b1;
          w_core_en   = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        w_ready     = 1'b1;
        w_state_nxt = ST_IDLE;
      end
`ifdef ARRAY_CLEAR_EN
      ST_CLEAR: begin
        w_core_en   = 1'b1;
        w_core_we   = 1'b1;
        w_core_addr = r_clr_addr;
        w_core_di   = '0;
        if (r_clr_addr == CLR_LAST) begin
          w_state_nxt = ST_IDLE;
        end
      end
`endif
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  ram_core_sp #(
    .ADDR_N (ADDR_N),
    .DATA_N (DATA_N),
    .DEPTH  (DEPTH)
  ) u_core (
    .i_clk  (i_clk),
    .i_en   (w_core_en & i_nrst),
    .i_we   (w_core_we),
    .i_addr (w_core_addr),
    .i_di   (w_core_di),
    .o_do   (w_core_do)
  );

  assign o_ready = w_ready;
  assign o_do    = r_do_zero ? '0 : w_core_do;

endmodule

// File: tb/tb_array_ram.sv
module tb_array_ram;

  localparam int unsigned AW    = 8;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 200;
  localparam int          TMO   = 1000;

  logic          clk = 1'b0;
  logic          nrst;
  logic [AW-1:0] addr;
  logic          we;
  logic [DW-1:0] di;
  logic          valid;
  logic [DW-1:0] dout;
  logic          ready;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: contents per address plus a "known" flag
  logic [DW-1:0] m_mem   [256];
  bit            m_known [256];

  always #5 clk = ~clk;

  array_ram #(.ADDR_N(AW), .DATA_N(DW), .DEPTH(DEPTH)) dut (
    .i_clk   (clk),
    .i_nrst  (nrst),
    .i_addr  (addr),
    .i_we    (we),
    .i_di    (di),
    .i_valid (valid),
    .o_do    (dout),
    .o_ready (ready)
  );

  function automatic void model_reset();
`ifdef ARRAY_CLEAR_EN
    for (int i = 0; i < 256; i++) begin
      m_mem[i]   = '0;
      m_known[i] = (i < int'(DEPTH));
    end
`endif
  endfunction

  function automatic int exp_lat_after_reset();
`ifdef ARRAY_CLEAR_EN
    return int'(DEPTH) + 1;
`else
    return 1;
`endif
  endfunction

  // Expected response per the spec rules, applied to the model.
  function automatic logic [DW-1:0] model_access(input logic [AW-1:0] a,
                                                  input logic w, input logic [DW-1:0] d);
    if (w) begin
      if (int'(a) < int'(DEPTH)) begin
        m_mem[a]   = d;
        m_known[a] = 1'b1;
      end
      return d;
    end
    if (int'(a) >= int'(DEPTH)) return '0;
    return m_mem[a];
  endfunction

  function automatic bit model_known(input logic [AW-1:0] a, input logic w);
    return w || (int'(a) >= int'(DEPTH)) || m_known[a];
  endfunction

  // Handshake only: present a request, wait (bounded) for ready, return
  // the response, latency in cycles and ready one cycle after the pulse.
  task automatic req(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d,
                     output logic [DW-1:0] rd, output int lat, output logic rdy_after);
    addr  = a;
    we    = w;
    di    = d;
    valid = 1'b1;
    lat   = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!ready && lat < TMO);
    rd    = dout;
    valid = 1'b0;
    @(posedge clk); #1;
    rdy_after = ready;
  endtask

  task automatic test_reset();
    logic [DW-1:0] rd;
    int lat;
    logic ra;
    nrst  = 1'b0;
    addr  = 8'd5;
    we    = 1'b1;
    di    = 8'd77;
    valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", ready); end
      n_cmp++;
      if (dout !== 8'd0) begin n_err++; $display("FAIL reset_do: got %0d want 0", dout); end
    end
    model_reset();
    nrst = 1'b1;
    req(8'd5, 1'b1, 8'd77, rd, lat, ra);
    void'(model_access(8'd5, 1'b1, 8'd77));
    n_cmp++;
    if (lat !== exp_lat_after_reset()) begin
      n_err++; $display("FAIL reset_first_accept_lat: got %0d want %0d", lat, exp_lat_after_reset());
    end
    n_cmp++;
    if (rd !== 8'd77) begin n_err++; $display("FAIL reset_first_do: got %0d want 77", rd); end
    n_cmp++;
    if (ra !== 1'b0) begin n_err++; $display("FAIL reset_first_pulse_len: ready %b want 0", ra); end
  endtask

  task automatic test_write_read();
    logic [DW-1:0] rd, e;
    int lat;
    logic ra;
    for (int k = 0; k < 2; k++) begin
      logic w;
      w = (k == 0);
      req(8'd3, w, 8'd42, rd, lat, ra);
      e = model_access(8'd3, w, 8'd42);
      n_cmp++;
      if (lat !== 1) begin n_err++; $display("FAIL wr_rd_lat[%0d]: got %0d want 1", k, lat); end
      n_cmp++;
      if (rd !== e) begin n_err++; $display("FAIL wr_rd_do[%0d]: got %0d want %0d", k, rd, e); end
      n_cmp++;
      if (ra !== 1'b0) begin n_err++; $display("FAIL wr_rd_pulse[%0d]: ready %b want 0", k, ra); end
    end
    for (int i = 0; i < 5; i++) begin
      addr = 8'($urandom);
      we   = 1'($urandom);
      di   = 8'($urandom);
      @(posedge clk); #1;
      n_cmp++;
      if (dout !== 8'd42 || ready !== 1'b0) begin
        n_err++; $display("FAIL idle_hold: do %0d ready %b want 42 0", dout, ready);
      end
    end
  endtask

  task automatic test_rmw();
    logic [DW-1:0] rd, e;
    int lat;
    logic ra;
    req(8'd3, 1'b0, 8'd0, rd, lat, ra);
    e = model_access(8'd3, 1'b0, 8'd0);
    n_cmp++;
    if (rd !== e || lat !== 1) begin n_err++; $display("FAIL rmw_read: do %0d lat %0d want %0d 1", rd, lat, e); end
    req(8'd3, 1'b1, rd + 8'd5, rd, lat, ra);
    e = model_access(8'd3, 1'b1, 8'd47);
    n_cmp++;
    if (rd !== e || lat !== 1) begin n_err++; $display("FAIL rmw_write: do %0d lat %0d want %0d 1", rd, lat, e); end
    req(8'd3, 1'b0, 8'd0, rd, lat, ra);
    n_cmp++;
    if (rd !== 8'd47) begin n_err++; $display("FAIL rmw_readback: do %0d want 47", rd); end
  endtask

  task automatic test_out_of_range();
    logic [7:0] a_tab [6] = '{8'd250, 8'd250, 8'd3, 8'd199, 8'd199, 8'd200};
    logic       w_tab [6] = '{1'b1,   1'b0,   1'b0, 1'b1,   1'b0,   1'b0};
    logic [7:0] d_tab [6] = '{8'd9,   8'd0,   8'd0, 8'd123, 8'd0,   8'd0};
    logic [DW-1:0] rd, e;
    int lat;
    logic ra;
    for (int i = 0; i < 6; i++) begin
      req(a_tab[i], w_tab[i], d_tab[i], rd, lat, ra);
      e = model_access(a_tab[i], w_tab[i], d_tab[i]);
      n_cmp++;
      if (rd !== e || lat !== 1 || ra !== 1'b0) begin
        n_err++;
        $display("FAIL oor[%0d] addr %0d: do %0d lat %0d ready_after %b want %0d 1 0",
                 i, a_tab[i], rd, lat, ra, e);
      end
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] rd, e, d;
    logic [AW-1:0] a;
    logic w;
    bit   kn;
    int lat;
    logic ra;
    for (int i = 0; i < 60; i++) begin
      a  = (i % 3 == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
      w  = 1'($urandom);
      d  = 8'($urandom);
      kn = model_known(a, w);
      req(a, w, d, rd, lat, ra);
      e = model_access(a, w, d);
      n_cmp++;
      if (lat !== 1 || ra !== 1'b0) begin
        n_err++; $display("FAIL rand_hs[%0d]: lat %0d ready_after %b want 1 0", i, lat, ra);
      end
      if (kn) begin
        n_cmp++;
        if (rd !== e) begin
          n_err++; $display("FAIL rand_do[%0d] addr %0d we %b: got %0d want %0d", i, a, w, rd, e);
        end
      end
    end
  endtask

  // Inputs change after acceptance and valid stays high through RESP.
  task automatic test_ignore_after_accept();
    logic [DW-1:0] rd;
    int lat;
    logic ra;
    addr = 8'd3; we = 1'b0; di = 8'd0; valid = 1'b1;
    @(posedge clk); #1;
    addr = 8'd3; we = 1'b1; di = 8'hFF;
    n_cmp++;
    if (ready !== 1'b1 || dout !== m_mem[3]) begin
      n_err++; $display("FAIL late_change_resp: ready %b do %0d want 1 %0d", ready, dout, m_mem[3]);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (ready !== 1'b0) begin n_err++; $display("FAIL resp_valid_ignored: ready %b want 0", ready); end
    valid = 1'b0;
    req(8'd3, 1'b0, 8'd0, rd, lat, ra);
    n_cmp++;
    if (rd !== m_mem[3]) begin n_err++; $display("FAIL no_write_in_resp: do %0d want %0d", rd, m_mem[3]); end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    addr = 8'd3; we = 1'b0; di = 8'd0; valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ready) pulses++;
      n_cmp++;
      if (ready !== ((i % 2) == 0)) begin
        n_err++; $display("FAIL b2b_pattern[%0d]: ready %b want %b", i, ready, (i % 2) == 0);
      end
    end
    valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (pulses !== 4) begin n_err++; $display("FAIL b2b_count: got %0d want 4", pulses); end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] rd;
    int lat;
    logic ra;
    addr = 8'd3; we = 1'b0; valid = 1'b1;
    @(posedge clk); #1;
    nrst = 1'b0;
    valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (ready !== 1'b0 || dout !== 8'd0) begin
      n_err++; $display("FAIL reset_mid: ready %b do %0d want 0 0", ready, dout);
    end
    model_reset();
    nrst = 1'b1;
    req(8'd3, 1'b0, 8'd0, rd, lat, ra);
    n_cmp++;
    if (lat !== exp_lat_after_reset() || rd !== m_mem[3]) begin
      n_err++; $display("FAIL reset_mid_readback: do %0d lat %0d want %0d %0d",
                        rd, lat, m_mem[3], exp_lat_after_reset());
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      m_mem[i]   = '0;
      m_known[i] = 1'b0;
    end
    nrst = 1'b0; addr = '0; we = 1'b0; di = '0; valid = 1'b0;
    test_reset();
    test_write_read();
    test_rmw();
    test_out_of_range();
    test_ignore_after_accept();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
